// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select and load-use stall detection for an in-order pipeline.
// Tracks in-flight producers beyond EX and counts stalled cycles.
module forward_hazard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int ADDR_W   = 5,
  parameter int LD_STAGE = 1,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0]  src,
  input  logic [NUM_SRC-1:0]         src_used,
  input  logic                       ex_valid,
  input  logic [ADDR_W-1:0]          ex_wa,
  input  logic                       ex_we,
  input  logic                       ex_ld,
  input  logic                       flush,
  input  logic                       cnt_clr,
  output logic [NUM_SRC*SEL_W-1:0]   fw_sel,
  output logic                       stall,
  output logic [31:0]                stall_cnt
);

  logic [ADDR_W-1:0] waReg [DEPTH];
  logic [DEPTH-1:0]  weReg;
  logic [DEPTH-1:0]  ldReg;
  logic [DEPTH-1:0]  entryLive;
  logic [NUM_SRC-1:0] blockedVec;
  logic [31:0]       stallCntReg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_live
      assign entryLive[gi] = weReg[gi] && (waReg[gi] != '0);
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [ADDR_W-1:0] srcAddr;
      logic [SEL_W-1:0]  selNext;
      logic              blockedNext;

      assign srcAddr = src[gi*ADDR_W +: ADDR_W];

      // Walk oldest to youngest so the youngest matching producer overrides.
      always_comb begin
        selNext     = '0;
        blockedNext = 1'b0;
        if (src_used[gi] && (srcAddr != '0)) begin
          for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entryLive[k] && (waReg[k] == srcAddr)) begin
              blockedNext = ldReg[k] && (k < LD_STAGE);
              selNext     = blockedNext ? '0 : SEL_W'(k + 1);
            end
          end
        end
      end

      assign fw_sel[gi*SEL_W +: SEL_W] = selNext;
      assign blockedVec[gi]            = blockedNext;
    end
  endgenerate

  assign stall     = ex_valid && (|blockedVec);
  assign stall_cnt = stallCntReg;

  // A stall inserts a bubble at entry 0 while older entries keep draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) waReg[k] <= '0;
      weReg <= '0;
      ldReg <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) waReg[k] <= '0;
      weReg <= '0;
      ldReg <= '0;
    end else begin
      waReg[0] <= stall ? '0 : ex_wa;
      weReg[0] <= !stall && ex_we && ex_valid;
      ldReg[0] <= !stall && ex_ld && ex_valid;
      for (int k = 1; k < DEPTH; k++) begin
        waReg[k] <= waReg[k-1];
        weReg[k] <= weReg[k-1];
        ldReg[k] <= ldReg[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntReg <= '0;
    end else if (cnt_clr) begin
      stallCntReg <= '0;
    end else if (stall && (stallCntReg != 32'hFFFF_FFFF)) begin
      stallCntReg <= stallCntReg + 32'd1;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed-vector bench for forward_hazard_unit with default parameters.
// Inputs change 1ns after each rising edge; outputs are checked before the next edge.
module tb_forward_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic [9:0]  src;
  logic [1:0]  src_used;
  logic        ex_valid;
  logic [4:0]  ex_wa;
  logic        ex_we;
  logic        ex_ld;
  logic        flush;
  logic        cnt_clr;
  logic [3:0]  fw_sel;
  logic        stall;
  logic [31:0] stall_cnt;

  int passCnt  = 0;
  int totalCnt = 0;

  forward_hazard_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .src_used  (src_used),
    .ex_valid  (ex_valid),
    .ex_wa     (ex_wa),
    .ex_we     (ex_we),
    .ex_ld     (ex_ld),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .fw_sel    (fw_sel),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setIn(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                       input logic v, input logic [4:0] wa, input logic we, input logic ld);
    src      = {s1, s0};
    src_used = used;
    ex_valid = v;
    ex_wa    = wa;
    ex_we    = we;
    ex_ld    = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    setIn(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    flush   = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic clearPipe();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    totalCnt++; if (fw_sel !== 4'd0) $display("FAIL reset_fw_sel got=%0h exp=0", fw_sel); else passCnt++;
    totalCnt++; if (stall !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", stall); else passCnt++;
    totalCnt++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt got=%0h exp=0", stall_cnt); else passCnt++;
    tick();
    #2 rst_n = 1'b1;
    tick();
    $display("reset: fw_sel=%0h stall=%0b stall_cnt=%0h", fw_sel, stall, stall_cnt);
  endtask

  task automatic test_alu_chain();
    clearPipe();
    setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    setIn(5'd3, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    totalCnt++; if (fw_sel[1:0] !== 2'd1) $display("FAIL alu_e0 got=%0d exp=1", fw_sel[1:0]); else passCnt++;
    totalCnt++; if (stall !== 1'b0) $display("FAIL alu_stall got=%0b exp=0", stall); else passCnt++;
    tick();
    totalCnt++; if (fw_sel[1:0] !== 2'd2) $display("FAIL alu_e1 got=%0d exp=2", fw_sel[1:0]); else passCnt++;
    tick();
    totalCnt++; if (fw_sel[1:0] !== 2'd3) $display("FAIL alu_e2 got=%0d exp=3", fw_sel[1:0]); else passCnt++;
    tick();
    totalCnt++; if (fw_sel[1:0] !== 2'd0) $display("FAIL alu_drop got=%0d exp=0", fw_sel[1:0]); else passCnt++;
    $display("alu_chain: r3 forwarded from entries 0,1,2 then dropped");
  endtask

  task automatic test_priority();
    clearPipe();
    setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    tick();
    setIn(5'd0, 5'd5, 2'b10, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    totalCnt++; if (fw_sel[3:2] !== 2'd1) $display("FAIL prio_src1 got=%0d exp=1", fw_sel[3:2]); else passCnt++;
    totalCnt++; if (fw_sel[1:0] !== 2'd0) $display("FAIL prio_src0 got=%0d exp=0", fw_sel[1:0]); else passCnt++;
    $display("priority: fw_sel1=%0d", fw_sel[3:2]);
  endtask

  task automatic test_load_use();
    clearPipe();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    setIn(5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    totalCnt++; if (stall !== 1'b0) $display("FAIL lu_invalid_stall got=%0b exp=0", stall); else passCnt++;
    totalCnt++; if (fw_sel[1:0] !== 2'd0) $display("FAIL lu_blocked_sel got=%0d exp=0", fw_sel[1:0]); else passCnt++;
    ex_valid = 1'b1;
    #1;
    totalCnt++; if (stall !== 1'b1) $display("FAIL lu_stall got=%0b exp=1", stall); else passCnt++;
    tick();
    totalCnt++; if (stall !== 1'b0) $display("FAIL lu_release got=%0b exp=0", stall); else passCnt++;
    totalCnt++; if (fw_sel[1:0] !== 2'd2) $display("FAIL lu_fwd got=%0d exp=2", fw_sel[1:0]); else passCnt++;
    totalCnt++; if (stall_cnt !== 32'd1) $display("FAIL lu_cnt got=%0h exp=1", stall_cnt); else passCnt++;
    $display("load_use: fw_sel0=%0d stall_cnt=%0h", fw_sel[1:0], stall_cnt);
  endtask

  task automatic test_r0_unused();
    clearPipe();
    setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    setIn(5'd0, 5'd0, 2'b01, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    totalCnt++; if (fw_sel[1:0] !== 2'd0) $display("FAIL r0_fwd got=%0d exp=0", fw_sel[1:0]); else passCnt++;
    tick();
    setIn(5'd0, 5'd4, 2'b00, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    totalCnt++; if (fw_sel[3:2] !== 2'd0) $display("FAIL unused_fwd got=%0d exp=0", fw_sel[3:2]); else passCnt++;
    src_used = 2'b10;
    #1;
    totalCnt++; if (fw_sel[3:2] !== 2'd1) $display("FAIL used_fwd got=%0d exp=1", fw_sel[3:2]); else passCnt++;
    $display("r0_unused: fw_sel=%0h", fw_sel);
  endtask

  task automatic test_flush();
    clearPipe();
    setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    setIn(5'd9, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    totalCnt++; if (fw_sel[1:0] !== 2'd0) $display("FAIL flush_fwd got=%0d exp=0", fw_sel[1:0]); else passCnt++;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    setIn(5'd7, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    totalCnt++; if (stall !== 1'b1) $display("FAIL flushstall_stall got=%0b exp=1", stall); else passCnt++;
    tick();
    flush = 1'b0;
    #1;
    totalCnt++; if (stall_cnt !== 32'd1) $display("FAIL flushstall_cnt got=%0h exp=1", stall_cnt); else passCnt++;
    totalCnt++; if (stall !== 1'b0) $display("FAIL flushstall_after got=%0b exp=0", stall); else passCnt++;
    totalCnt++; if (fw_sel[1:0] !== 2'd0) $display("FAIL flushstall_fwd got=%0d exp=0", fw_sel[1:0]); else passCnt++;
    $display("flush: stall_cnt=%0h fw_sel0=%0d", stall_cnt, fw_sel[1:0]);
  endtask

  task automatic test_reset_mid_stall();
    clearPipe();
    setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    setIn(5'd7, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    totalCnt++; if (stall !== 1'b1) $display("FAIL rstmid_pre got=%0b exp=1", stall); else passCnt++;
    #1 rst_n = 1'b0;
    #1;
    totalCnt++; if (stall !== 1'b0) $display("FAIL rstmid_stall got=%0b exp=0", stall); else passCnt++;
    totalCnt++; if (stall_cnt !== 32'd0) $display("FAIL rstmid_cnt got=%0h exp=0", stall_cnt); else passCnt++;
    tick();
    #2 rst_n = 1'b1;
    tick();
    totalCnt++; if (fw_sel[1:0] !== 2'd0) $display("FAIL rstmid_stale got=%0d exp=0", fw_sel[1:0]); else passCnt++;
    totalCnt++; if (stall !== 1'b0) $display("FAIL rstmid_after got=%0b exp=0", stall); else passCnt++;
    $display("reset_mid_stall: stall=%0b stall_cnt=%0h", stall, stall_cnt);
  endtask

  task automatic loadUse(input logic clr);
    setIn(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    setIn(5'd7, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0);
    cnt_clr = clr;
    tick();
    idle();
  endtask

  task automatic test_counter();
    clearPipe();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) loadUse(i == 1);
    totalCnt++; if (stall_cnt !== 32'd1) $display("FAIL cnt_clr_prio got=%0h exp=1", stall_cnt); else passCnt++;
    force dut.stallCntReg = 32'hFFFF_FFFE;
    #1 release dut.stallCntReg;
    loadUse(1'b0);
    totalCnt++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL cnt_reach_max got=%0h exp=ffffffff", stall_cnt); else passCnt++;
    loadUse(1'b0);
    totalCnt++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL cnt_saturate got=%0h exp=ffffffff", stall_cnt); else passCnt++;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    totalCnt++; if (stall_cnt !== 32'd0) $display("FAIL cnt_clear got=%0h exp=0", stall_cnt); else passCnt++;
    $display("counter: stall_cnt=%0h", stall_cnt);
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_priority();
    test_load_use();
    test_r0_unused();
    test_flush();
    test_reset_mid_stall();
    test_counter();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
